call_stack_ctrl: RTL
====================

Name: call_stack_ctrl

Overview:
- Initiator side of the stack interface: the microprocessor's subroutine CALL/RET sequencer.
- On CALL it pushes the return address (PC_IN+1) onto the stack and loads the branch target into the PC.
- On RET it pops the stack and loads the popped address into the PC.
- Stack overflow on CALL and stack underflow on RET raise a sticky fault.

Parameters:
- DATA_WIDTH, 8, width of PC values and of stack words.
- LEVEL_WIDTH, 4, width of the LEVEL occupancy counter (used only with DEPTH_COUNT_EN).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- CALL  input  1  call request; sampled in IDLE only.
- RET  input  1  return request; sampled in IDLE only.
- TARGET  input  DATA_WIDTH  call target address; latched with CALL.
- PC_IN  input  DATA_WIDTH  current PC; latched with CALL.
- CLR_FAULT  input  1  clears FAULT state.
- PC_OUT  output  DATA_WIDTH  new PC value; valid while PC_LOAD=1.
- PC_LOAD  output  1  one-cycle strobe: load PC_OUT into the PC.
- BUSY  output  1  high in every state except IDLE.
- FAULT  output  1  high in FAULT state.
- FAULT_CODE  output  2  00 none, 01 overflow, 10 underflow.
- STK_DATA_IN  output  DATA_WIDTH  word to push; drives the stack DATA_IN.
- STK_CE  output  1  stack chip enable.
- STK_nRW  output  1  1 = push, 0 = pop.
- STK_DATA_OUT  input  DATA_WIDTH  stack read data; valid the cycle after the pop edge.
- STK_FULL  input  1  stack full flag.
- STK_EMPTY  input  1  stack empty flag.

Behaviour:
- Reset (async, RST=1) forces:
  - state IDLE;
  - PC_OUT=0, PC_LOAD=0, BUSY=0, FAULT=0, FAULT_CODE=00;
  - STK_CE=0, STK_nRW=0, STK_DATA_IN=0;
  - internal target/return registers cleared.
- Outputs decode from state and registers only (Moore); there is no combinational path from CALL/RET to STK_CE.
- States: IDLE, PUSH, POP, WAIT, LOAD, FAULT.
- IDLE:
  - CALL=1 and STK_FULL=0: latch TARGET, latch ret=PC_IN+1 (mod 2^DATA_WIDTH; 0xFF+1 wraps to 0x00), go to PUSH.
  - CALL=1 and STK_FULL=1: go to FAULT with code 01. No stack access.
  - RET=1 (CALL=0) and STK_EMPTY=0: go to POP.
  - RET=1 (CALL=0) and STK_EMPTY=1: go to FAULT with code 10.
  - CALL and RET both high: CALL wins; the RET is dropped, not queued.
- PUSH (one cycle): STK_CE=1, STK_nRW=1, STK_DATA_IN=ret. The stack writes on the next edge; then go to LOAD with PC_OUT=target.
- POP (one cycle): STK_CE=1, STK_nRW=0; go to WAIT.
- WAIT (one cycle): STK_CE=0. Capture STK_DATA_OUT into PC_OUT at the exiting edge; go to LOAD.
- LOAD (one cycle): PC_LOAD=1; go to IDLE. PC_OUT holds its value until the next load.
- FAULT:
  - sticky; BUSY=1, FAULT=1; STK_CE held 0.
  - CLR_FAULT=1 returns to IDLE and sets FAULT_CODE=00.
  - CALL/RET are ignored while in FAULT.
- STK_CE is high for exactly one cycle per accepted CALL or RET and is never high outside PUSH/POP.
- Latency from the edge that samples the request:
  - CALL: PC_LOAD high 2 cycles later (IDLE→PUSH→LOAD).
  - RET: PC_LOAD high 3 cycles later (IDLE→POP→WAIT→LOAD).
- CALL/RET asserted while BUSY are ignored and must be held or re-issued by the requester.
- Reset asserted mid-operation aborts immediately. A push or pop already clocked into the stack is not undone. STK_CE drops asynchronously.

Optional Feature:
- Macro: DEPTH_COUNT_EN.
- Defined:
  - adds output port LEVEL [LEVEL_WIDTH-1:0], reset to 0;
  - LEVEL increments on the edge leaving PUSH and decrements on the edge leaving POP;
  - saturates at 0 and at all-ones, with no wrap.
- Undefined: LEVEL port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: RST pulse → all outputs 0, STK_CE never asserted over 10 cycles.
- CALL with PC_IN=0x10, TARGET=0x40, stack empty → one cycle STK_CE=1/STK_nRW=1/STK_DATA_IN=0x11, then PC_LOAD=1 with PC_OUT=0x40, then IDLE.
- RET after the previous CALL, with the stack model returning 0x11 → STK_CE=1/STK_nRW=0 for one cycle, WAIT, PC_LOAD=1 with PC_OUT=0x11. With DEPTH_COUNT_EN, LEVEL goes 1→0.
- Nested CALLs with PC_IN=0x05, 0x20, 0xFF, then three RETs → pushes 0x06, 0x21, 0x00 (wrap); PC_OUT sequence on RETs is 0x00, 0x21, 0x06.
- CALL with STK_FULL=1 → FAULT=1, FAULT_CODE=01, no STK_CE; later CALL ignored; CLR_FAULT → IDLE, code 00. RET with STK_EMPTY=1 → FAULT_CODE=10.
- CALL and RET in the same cycle (PC_IN=0x30, TARGET=0x50) → push of 0x31, PC_OUT=0x50, no pop. RST asserted during WAIT → immediate IDLE with PC_LOAD=0.

Source files
------------

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl
//   Subroutine CALL/RET sequencer that drives an external hardware stack.
//   On CALL it pushes the return address (PC_IN+1) and then loads TARGET
//   into the PC. On RET it pops the stack and then loads the popped word
//   into the PC. A CALL against a full stack or a RET against an empty
//   stack parks the controller in a sticky FAULT state until CLR_FAULT.
//
//   Optional feature macro: DEPTH_COUNT_EN
//     When defined, an extra LEVEL output tracks the stack occupancy.
//     The counter saturates at 0 and at all-ones.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   CALL, RET         requests, sampled only in IDLE (CALL has priority)
//   TARGET, PC_IN     call target and current PC, latched with CALL
//   CLR_FAULT         leaves the FAULT state
//   PC_OUT, PC_LOAD   new PC value and its one-cycle load strobe
//   BUSY, FAULT       status; FAULT_CODE 01 overflow, 10 underflow
//   STK_DATA_IN       word to push
//   STK_CE, STK_nRW   stack enable, direction (1 push, 0 pop)
//   STK_DATA_OUT      pop data, valid the cycle after the pop edge
//   STK_FULL/EMPTY    stack flags
//   LEVEL             occupancy counter (DEPTH_COUNT_EN only)
module call_stack_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEVEL_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CALL,
  input  logic                   RET,
  input  logic [DATA_WIDTH-1:0]  TARGET,
  input  logic [DATA_WIDTH-1:0]  PC_IN,
  input  logic                   CLR_FAULT,
  output logic [DATA_WIDTH-1:0]  PC_OUT,
  output logic                   PC_LOAD,
  output logic                   BUSY,
  output logic                   FAULT,
  output logic [1:0]             FAULT_CODE,
  output logic [DATA_WIDTH-1:0]  STK_DATA_IN,
  output logic                   STK_CE,
  output logic                   STK_nRW,
  input  logic [DATA_WIDTH-1:0]  STK_DATA_OUT,
  input  logic                   STK_FULL,
  input  logic                   STK_EMPTY
`ifdef DEPTH_COUNT_EN
  ,
  output logic [LEVEL_WIDTH-1:0] LEVEL
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_WAIT,
    S_LOAD,
    S_FAULT
  } state_t;

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_OVERFLOW  = 2'b01;
  localparam logic [1:0] CODE_UNDERFLOW = 2'b10;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   target_q;
  logic [DATA_WIDTH-1:0]   ret_q;
  logic [DATA_WIDTH-1:0]   pc_out_q;
  logic [1:0]              fault_code_q;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; CALL beats RET when both are present in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (CALL) begin
          state_d = STK_FULL ? S_FAULT : S_PUSH;
        end else if (RET) begin
          state_d = STK_EMPTY ? S_FAULT : S_POP;
        end
      end
      S_PUSH:  state_d = S_LOAD;
      S_POP:   state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      S_FAULT: begin
        if (CLR_FAULT) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and fault-code registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      target_q     <= '0;
      ret_q        <= '0;
      pc_out_q     <= '0;
      fault_code_q <= CODE_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CALL) begin
            if (STK_FULL) begin
              fault_code_q <= CODE_OVERFLOW;
            end else begin
              target_q <= TARGET;
              // Natural wrap: PC 0xFF returns to 0x00
              ret_q    <= PC_IN + DATA_WIDTH'(1);
            end
          end else if (RET && STK_EMPTY) begin
            fault_code_q <= CODE_UNDERFLOW;
          end
        end
        S_PUSH:  pc_out_q <= target_q;
        // Pop data arrives one cycle after the pop edge, so it is taken here
        S_WAIT:  pc_out_q <= STK_DATA_OUT;
        S_FAULT: begin
          if (CLR_FAULT) begin
            fault_code_q <= CODE_NONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DEPTH_COUNT_EN
  logic [LEVEL_WIDTH-1:0] level_q;

  function automatic logic [LEVEL_WIDTH-1:0] level_inc_sat(
    input logic [LEVEL_WIDTH-1:0] v
  );
    return (&v) ? v : v + LEVEL_WIDTH'(1);
  endfunction

  function automatic logic [LEVEL_WIDTH-1:0] level_dec_sat(
    input logic [LEVEL_WIDTH-1:0] v
  );
    return (v == '0) ? v : v - LEVEL_WIDTH'(1);
  endfunction

  // Occupancy tracks the edge that actually commits the stack access
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q <= '0;
    end else if (state_q == S_PUSH) begin
      level_q <= level_inc_sat(level_q);
    end else if (state_q == S_POP) begin
      level_q <= level_dec_sat(level_q);
    end
  end

  assign LEVEL = level_q;
`endif

  // Moore outputs: the stack strobe depends on state only, so reset
  // removes it immediately
  assign STK_CE      = (state_q == S_PUSH) || (state_q == S_POP);
  assign STK_nRW     = (state_q == S_PUSH);
  assign STK_DATA_IN = ret_q;
  assign PC_OUT      = pc_out_q;
  assign PC_LOAD     = (state_q == S_LOAD);
  assign BUSY        = (state_q != S_IDLE);
  assign FAULT       = (state_q == S_FAULT);
  assign FAULT_CODE  = fault_code_q;

endmodule
